mem_data_arbiter: RTL

//  Shares the memory data port (read port 1 + write port) among NREQ requesters.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_data_arbiter_if.sv | 26 ++
 rtl/mem_data_arbiter_rr_picker.sv | 23 ++
 rtl/mem_data_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, response tag type and pointer helper for the memory data arbiter.
package mem_arb_pkg;
  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int MAX_NREQ = 4;

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } rsp_tag_t;

  // Round-robin successor of requester i among n requesters.
  function automatic logic [1:0] next_idx(logic [1:0] i, int n);
    return (int'(i) + 1 >= n) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/mem_data_arbiter_if.sv
// Requester and memory-port bundle of the memory data arbiter.
interface mem_data_arbiter_if #(parameter int NREQ = 2) ();
  import mem_arb_pkg::*;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]           rsp_data;
  logic [ADDR_W-1:0]           mem_raddr;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        mem_wen;
  logic [ADDR_W-1:0]           mem_waddr;
  logic [DATA_W-1:0]           mem_wdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_raddr, mem_wen, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/mem_data_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(parameter int N = 2) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         any_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any_o && req_i[j] && j == (int'(ptr_i) + k) % N) begin
          any_o    = 1'b1;
          gnt_o[j] = 1'b1;
          idx_o    = 2'(j);
        end
      end
    end
  end
endmodule

// File: rtl/mem_data_arbiter.sv
// Shares the memory data port among NREQ requesters; one access per cycle,
// load data routed back to its issuer RD_LAT cycles after the grant.
module mem_data_arbiter import mem_arb_pkg::*; #(
  parameter int NREQ   = 2,
  parameter int RD_LAT = 2,
  parameter int FIXED0 = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_data_arbiter_if.slave bus
);
  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("mem_data_arbiter: NREQ must be 2..4");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("mem_data_arbiter: RD_LAT must be 1..4");
  end

  logic [1:0]              rr_q, rr_d;
  rsp_tag_t [RD_LAT-1:0]   tag_q;
  rsp_tag_t                tap;
  logic [DATA_W-1:0]       rdata_q, rsp_data_d;
  logic [NREQ-1:0]         live, pick_req, pick_gnt, gnt;
  logic [1:0]              pick_idx, win;
  logic                    pick_any, any, is_st, is_ld;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  // Grant is suppressed while reset is held so nothing is accepted then.
  assign live = bus.req_valid & {NREQ{rst_n}};

  always_comb begin
    pick_req = live;
    if (FIXED0 != 0) pick_req[0] = 1'b0;
  end

  rr_picker #(.N(NREQ)) u_pick (
    .req_i (pick_req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    if (FIXED0 != 0 && live[0]) begin
      gnt = {{(NREQ-1){1'b0}}, 1'b1};
      win = '0;
      any = 1'b1;
    end else begin
      gnt = pick_gnt;
      win = pick_idx;
      any = pick_any;
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = bus.req_addr[i];
        sel_wdata = bus.req_wdata[i];
      end
    end
  end

  assign is_st = |(gnt & bus.req_we);
  assign is_ld = |(gnt & ~bus.req_we);

  assign bus.req_ready = gnt;
  assign bus.mem_wen   = is_st;
  assign bus.mem_waddr = is_st ? sel_addr  : '0;
  assign bus.mem_wdata = is_st ? sel_wdata : '0;
  assign bus.mem_raddr = is_ld ? sel_addr  : '0;

  always_comb begin
    rr_d = rr_q;
    if (any) rr_d = next_idx(win, NREQ);
  end

  assign tap = tag_q[RD_LAT-1];

  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tap.vld && tap.id == 2'(i)) bus.rsp_valid[i] = 1'b1;
    end
  end

  // Outside a response slot the last returned word is held.
  assign rsp_data_d   = tap.vld ? bus.mem_rdata : rdata_q;
  assign bus.rsp_data = rsp_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
    end else begin
      rr_q     <= rr_d;
      rdata_q  <= rsp_data_d;
      tag_q[0] <= rsp_tag_t'{vld: is_ld, id: win};
      for (int k = RD_LAT - 1; k > 0; k--) tag_q[k] <= tag_q[k-1];
    end
  end
endmodule
